// File: rtl/freq_mult_sched_pkg.sv
// Shared definitions for the FreqMult round-robin scheduler.
package freq_mult_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADJ,
    ST_WAIT,
    ST_CAPT
  } state_e;

  // Default number of RefClk cycles to wait for a fresh FreqMult lock.
  localparam int TO_CYC_DEFAULT = 50000;

endpackage

// File: rtl/freq_mult_sched_rr_pick.sv
// Round-robin priority picker: the first eligible client at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW:0]   slot_sum;
  logic [IW-1:0] slot;

  // Scan outward from rr_ptr and keep only the first eligible hit.
  always_comb begin
    // NOTE: every output gets a default first so no latch appears on the no-eligible path.
    sel      = '0;
    idx      = '0;
    found    = 1'b0;
    slot_sum = '0;
    slot     = '0;
    for (int off = 0; off < NREQ; off++) begin
      slot_sum = {1'b0, rr_ptr} + (IW+1)'(off);
      if (slot_sum >= (IW+1)'(NREQ)) slot_sum = slot_sum - (IW+1)'(NREQ);
      slot = slot_sum[IW-1:0];
      if (!found && eligible[slot]) begin
        found     = 1'b1;
        sel[slot] = 1'b1;
        idx       = slot;
      end
    end
  end

endmodule

// File: rtl/freq_mult_sched.sv
// Shares one FreqMult between NREQ clients: grant, pulse adjust, wait for lock or timeout, ack.
module freq_mult_sched
  import freq_mult_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int N_W    = 3,
  parameter int SD_W   = 16,
  parameter int TO_CYC = TO_CYC_DEFAULT
) (
  input  logic              RefClk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N_W-1:0] req_n,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic [SD_W-1:0]   result,
  output logic              busy,
  output logic              fm_adjust,
  output logic [N_W-1:0]    fm_n,
  input  logic              fm_done,
  input  logic [SD_W-1:0]   fm_sd
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TO_CYC);

  state_e          state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   gidx_q;
  logic [NREQ-1:0] served_q, served_d;
  logic [TW-1:0]   tmo_q;
  logic            done_q;
  logic            to_flag_q;
  logic [NREQ-1:0] grant_q, ack_q;
  logic            err_q, adjust_q;
  logic [SD_W-1:0] result_q;
  logic [N_W-1:0]  fm_n_q;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;

  // A client that was served stays blocked until it withdraws its request.
  assign eligible = req & ~served_q;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .sel      (pick_sel),
    .idx      (pick_idx)
  );

  // Served mask: set for the client being acked, cleared wherever its request is low.
  always_comb begin
    served_d = served_q;
    if (state_q == ST_CAPT) served_d = served_d | grant_q;
    served_d = served_d & req;
  end

  // Scheduler FSM with registered outputs; reset aborts any transaction without an ack.
  always_ff @(posedge RefClk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      served_q  <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      to_flag_q <= 1'b0;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      adjust_q  <= 1'b0;
      result_q  <= '0;
      fm_n_q    <= '0;
    end else begin
      done_q   <= fm_done;
      served_q <= served_d;
      ack_q    <= '0;
      err_q    <= 1'b0;
      adjust_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (|eligible) state_q <= ST_ARB;
        ST_ARB: begin
          if (|eligible) begin
            grant_q <= pick_sel;
            gidx_q  <= pick_idx;
            fm_n_q  <= req_n[pick_idx*N_W +: N_W];
            state_q <= ST_ADJ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADJ: begin
          adjust_q  <= 1'b1;
          tmo_q     <= '0;
          to_flag_q <= 1'b0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // Only a fresh lock edge counts; a level left high from before ADJ is ignored.
          if (fm_done && !done_q) begin
            state_q <= ST_CAPT;
          end else if (tmo_q == TW'(TO_CYC - 1)) begin
            to_flag_q <= 1'b1;
            state_q   <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          ack_q    <= grant_q;
          err_q    <= to_flag_q;
          if (!to_flag_q) result_q <= fm_sd;
          rr_ptr_q <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
          grant_q  <= '0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign result    = result_q;
  assign busy      = (state_q != ST_IDLE);
  assign fm_adjust = adjust_q;
  assign fm_n      = fm_n_q;

endmodule

// File: tb/tb_freq_mult_sched.sv
// Self-checking bench for freq_mult_sched: directed table, hand sequences, randomized traffic.
module tb_freq_mult_sched;

  localparam int NREQ   = 4;
  localparam int N_W    = 3;
  localparam int SD_W   = 16;
  localparam int TO_CYC = 64;

  logic        RefClk = 1'b0;
  logic        rst    = 1'b1;
  logic [3:0]  req    = '0;
  logic [11:0] req_n  = '0;
  logic        fm_done = 1'b0;
  logic [15:0] fm_sd  = '0;
  logic [3:0]  grant, ack;
  logic        err, busy, fm_adjust;
  logic [15:0] result;
  logic [2:0]  fm_n;

  freq_mult_sched #(.NREQ(NREQ), .N_W(N_W), .SD_W(SD_W), .TO_CYC(TO_CYC)) dut (
    .RefClk    (RefClk),
    .rst       (rst),
    .req       (req),
    .req_n     (req_n),
    .grant     (grant),
    .ack       (ack),
    .err       (err),
    .result    (result),
    .busy      (busy),
    .fm_adjust (fm_adjust),
    .fm_n      (fm_n),
    .fm_done   (fm_done),
    .fm_sd     (fm_sd)
  );

  always #5 RefClk = ~RefClk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model of the scheduler's visible bookkeeping.
  int          m_ptr;
  logic [3:0]  m_served;
  logic [15:0] m_result;

  typedef struct {
    logic [3:0]  drop;
    logic [3:0]  req;
    logic [11:0] req_n;
    int          d;
    bit          tmo;
    logic [15:0] sd;
    int          exp_g;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge RefClk);
  endtask

  // Winner of a round-robin scan starting at ptr.
  function automatic int pick(input logic [3:0] elig, input int ptr);
    for (int off = 0; off < NREQ; off++)
      if (elig[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  // One full transaction, started at a negedge with the DUT idle and req already applied.
  // d = cycles after the adjust pulse is seen before fm_done rises; tmo = done held high throughout.
  task automatic run_txn(input int g, input int d, input bit tmo, input logic [15:0] sd,
                         input logic [15:0] exp_res);
    int         lat;
    logic [3:0] gprev;
    logic [2:0] exp_n;
    exp_n = req_n[g*N_W +: N_W];
    if (tmo) fm_done = 1'b1;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step();
      if (fm_adjust) lat = c;
    end
    check("adjust_latency", lat, 3);
    check("grant", grant, 32'(1) << g);
    check("fm_n", fm_n, exp_n);
    check("busy", busy, 1);
    fm_sd = sd;
    if (!tmo && d == 0) fm_done = 1'b1;
    lat   = 0;
    gprev = '0;
    for (int t = 1; t <= TO_CYC + 8 && lat == 0; t++) begin
      step();
      if (t == 1) check("adjust_pulse_width", fm_adjust, 0);
      if (ack != 0) lat = t;
      else begin
        gprev = grant;
        if (!tmo && t == d) fm_done = 1'b1;
      end
    end
    check("ack_latency", lat, tmo ? TO_CYC + 1 : d + 2);
    check("ack", ack, 32'(1) << g);
    check("err", err, tmo);
    check("result", result, exp_res);
    check("grant_before_ack", gprev, 32'(1) << g);
    check("grant_cleared", grant, 0);
    fm_done = 1'b0;
    if (!tmo) m_result = sd;
    m_ptr = (g + 1) % NREQ;
    if (req[g]) m_served[g] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g, dd, lat;
    bit          tm;
    logic [3:0]  nr, el;
    logic [15:0] sd;
    logic        seen;

    vecs[0] = '{4'b0000, 4'b0001, 12'o7653, 40, 1'b0, 16'h1234, 0, 16'h1234};
    vecs[1] = '{4'b0000, 4'b1111, 12'o1234,  5, 1'b0, 16'h0aaa, 1, 16'h0aaa};
    vecs[2] = '{4'b0000, 4'b1111, 12'o4567,  0, 1'b0, 16'h5555, 2, 16'h5555};
    vecs[3] = '{4'b0000, 4'b1111, 12'o0123, 12, 1'b0, 16'hbeef, 3, 16'hbeef};
    vecs[4] = '{4'b0001, 4'b1111, 12'o2222,  0, 1'b1, 16'h9999, 0, 16'hbeef};
    vecs[5] = '{4'b1111, 4'b0010, 12'o0070,  3, 1'b0, 16'h0101, 1, 16'h0101};
    vecs[6] = '{4'b0010, 4'b1001, 12'o5006,  7, 1'b0, 16'h3333, 3, 16'h3333};
    vecs[7] = '{4'b0000, 4'b1011, 12'o0061,  1, 1'b0, 16'h7777, 0, 16'h7777};

    // Reset state.
    repeat (3) step();
    check("rst_grant", grant, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_fm_adjust", fm_adjust, 0);
    check("rst_fm_n", fm_n, 0);
    rst      = 1'b0;
    m_ptr    = 0;
    m_served = '0;
    m_result = '0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].drop != 0) begin
        req = req & ~vecs[i].drop;
        m_served &= req;
        step();
        check("idle_after_drop", busy, 0);
      end
      req   = vecs[i].req;
      req_n = vecs[i].req_n;
      m_served &= req;
      run_txn(vecs[i].exp_g, vecs[i].d, vecs[i].tmo, vecs[i].sd, vecs[i].exp_res);
      if (i == 3) begin
        step();
        check("ack_one_cycle", ack, 0);
        seen = 1'b0;
        repeat (10) begin
          step();
          seen = seen | busy | (|grant);
        end
        check("no_regrant_while_served", seen, 0);
      end
    end

    // req[1] withdrawn during WAIT: transaction still completes and acks.
    fm_sd = 16'h4242;
    lat   = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step();
      if (fm_adjust) lat = c;
    end
    check("drop_adjust_latency", lat, 3);
    check("drop_grant", grant, 4'b0010);
    check("drop_fm_n", fm_n, 3'd6);
    step();
    step();
    req   = 4'b1001;
    req_n = 12'o0071;
    step();
    fm_done = 1'b1;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      step();
      if (ack != 0) lat = c;
    end
    check("drop_ack_latency", lat, 2);
    check("drop_ack", ack, 4'b0010);
    check("drop_err", err, 0);
    check("drop_result", result, 16'h4242);
    check("drop_fm_n_held", fm_n, 3'd6);
    fm_done  = 1'b0;
    m_result = 16'h4242;
    m_ptr    = 2;
    m_served &= req;
    req = 4'b1011;
    run_txn(1, 4, 1'b0, 16'h2468, 16'h2468);

    // Reset during WAIT aborts; next request restarts the pointer at client 0.
    req   = 4'b0100;
    req_n = 12'o0500;
    m_served &= req;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      step();
      if (fm_adjust) lat = c;
    end
    check("abort_adjust_latency", lat, 3);
    check("abort_grant", grant, 4'b0100);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("abort_grant_zero", grant, 0);
    check("abort_ack_zero", ack, 0);
    check("abort_err_zero", err, 0);
    check("abort_result_zero", result, 0);
    check("abort_busy_zero", busy, 0);
    check("abort_adjust_zero", fm_adjust, 0);
    check("abort_fm_n_zero", fm_n, 0);
    rst      = 1'b0;
    req      = 4'b1001;
    m_served = '0;
    m_ptr    = 0;
    m_result = '0;
    run_txn(0, 6, 1'b0, 16'hc0de, 16'hc0de);

    // Randomized traffic against the model.
    for (int it = 0; it < 50; it++) begin
      nr    = 4'($urandom_range(0, 15));
      req_n = 12'($urandom);
      req   = nr;
      m_served &= nr;
      el = nr & ~m_served;
      if (el == 0) begin
        step();
        step();
        check("rand_idle", busy, 0);
      end else begin
        g  = pick(el, m_ptr);
        tm = ($urandom_range(0, 7) == 0);
        dd = $urandom_range(0, 15);
        sd = 16'($urandom);
        run_txn(g, dd, tm, sd, tm ? m_result : sd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
